// File: rtl/rms_scale_ctrl_if.sv
// Stream handshake bundle used for the sample input, the inverse-sqrt
// request/response pair and the scale-factor output.
interface rms_scale_ctrl_if;
  logic [15:0] TDATA;
  logic        TVALID;
  logic        TLAST;
  logic        TREADY;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/rms_scale_ctrl.sv
// RMS-normalisation front end: sum of squares over N Q8.8 samples, mean-square
// plus epsilon to bf16, round trip through the inverse-sqrt stage, scale out.
module rms_scale_ctrl #(
  parameter int unsigned LOG2_N = 6,
  parameter logic [31:0] EPS    = 32'h0000_0001
) (
  input  logic              aclk,
  input  logic              areset,
  rms_scale_ctrl_if.slave   s_axis,
  rms_scale_ctrl_if.master  m_axis_rsq,
  rms_scale_ctrl_if.slave   s_axis_rsq,
  rms_scale_ctrl_if.master  m_axis,
  output logic              err_tlast
);

  localparam int unsigned ACC_W = 32 + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_MEAN,
    ST_CONV,
    ST_SEND,
    ST_WAIT_RSQ,
    ST_OUT
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        v_q, v_d;
  logic [15:0]        rsq_q, rsq_d;
  logic [15:0]        scale_q, scale_d;
  logic               err_q, err_d;

  logic               s_rdy, rsq_vld, ret_rdy, out_vld;
  logic signed [15:0] x;
  logic signed [31:0] sq;

  // Unsigned Q16.16 to bf16, round to nearest even; the leading one is
  // normalised to bit 31 so short values zero-fill the mantissa naturally.
  function automatic logic [15:0] to_bf16(input logic [31:0] v);
    logic [4:0]  p;
    logic [31:0] n;
    logic [14:0] em;
    logic        rnd;
    logic        sticky;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) p = 5'(i);
    end
    n      = v << (5'd31 - p);
    em     = {8'(p) + 8'd111, n[30:24]};
    rnd    = n[23];
    sticky = |n[22:0];
    if (rnd && (sticky || n[24])) em = em + 15'd1;
    return (v == '0) ? 16'h0000 : {1'b0, em};
  endfunction

  assign x  = s_axis.TDATA;
  assign sq = x * x;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    rsq_d   = rsq_q;
    scale_d = scale_q;
    err_d   = 1'b0;
    s_rdy   = 1'b0;
    rsq_vld = 1'b0;
    ret_rdy = 1'b0;
    out_vld = 1'b0;
    unique case (state_q)
      ST_ACCUM: begin
        s_rdy = 1'b1;
        if (s_axis.TVALID) begin
          acc_d = acc_q + ACC_W'($unsigned(sq));
          cnt_d = cnt_q + CNT_W'(1);
          err_d = s_axis.TLAST != (cnt_q == CNT_LAST);
          // The vector closes on the count alone; TLAST only feeds err_tlast.
          if (cnt_q == CNT_LAST) state_d = ST_MEAN;
        end
      end
      ST_MEAN: begin
        v_d     = 32'(acc_q >> LOG2_N) + EPS;
        state_d = ST_CONV;
      end
      ST_CONV: begin
        rsq_d   = to_bf16(v_q);
        state_d = ST_SEND;
      end
      ST_SEND: begin
        rsq_vld = 1'b1;
        if (m_axis_rsq.TREADY) state_d = ST_WAIT_RSQ;
      end
      ST_WAIT_RSQ: begin
        ret_rdy = 1'b1;
        if (s_axis_rsq.TVALID) begin
          scale_d = s_axis_rsq.TDATA;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        out_vld = 1'b1;
        if (m_axis.TREADY) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      v_q     <= '0;
      rsq_q   <= '0;
      scale_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      rsq_q   <= rsq_d;
      scale_q <= scale_d;
      err_q   <= err_d;
    end
  end

  // Sample ready is held low for the whole reset, including before the first edge.
  assign s_axis.TREADY     = s_rdy & ~areset;
  assign m_axis_rsq.TDATA  = rsq_q;
  assign m_axis_rsq.TVALID = rsq_vld;
  assign m_axis_rsq.TLAST  = 1'b1;
  assign s_axis_rsq.TREADY = ret_rdy;
  assign m_axis.TDATA      = scale_q;
  assign m_axis.TVALID     = out_vld;
  assign m_axis.TLAST      = 1'b1;
  assign err_tlast         = err_q;

endmodule

// File: doc/rms_scale_ctrl.md
# rms_scale_ctrl

RMS-normalisation front end for the Norm datapath. It is the stream producer and consumer around the bf16 reciprocal-square-root stage.
- Accepts a vector of N signed Q8.8 samples and accumulates the sum of squares.
- Forms mean-square + epsilon and converts it to bf16.
- Sends that bf16 value to the inverse-sqrt stage on an AXI-Stream master.
- Takes the bf16 1/sqrt result back on an AXI-Stream slave and emits it as the vector's scale factor.

## Interface
Parameters:
- LOG2_N, 6, log2 of vector length N (N = 64 by default); legal range 0..8.
- EPS, 32'h0000_0001, epsilon added to mean-square; unsigned Q16.16.

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- S_AXIS_TDATA  in  16  input sample, signed Q8.8.
- S_AXIS_TVALID  in  1  sample valid.
- S_AXIS_TLAST  in  1  marks sample N-1 of a vector.
- S_AXIS_TREADY  out  1  sample ready.
- M_AXIS_RSQ_TDATA  out  16  bf16 (mean-square + EPS), to inverse-sqrt stage.
- M_AXIS_RSQ_TVALID  out  1  valid toward inverse-sqrt stage.
- M_AXIS_RSQ_TREADY  in  1  ready from inverse-sqrt stage.
- S_AXIS_RSQ_TDATA  in  16  bf16 1/sqrt result from inverse-sqrt stage.
- S_AXIS_RSQ_TVALID  in  1  result valid.
- S_AXIS_RSQ_TREADY  out  1  result ready.
- M_AXIS_TDATA  out  16  bf16 scale factor for the vector.
- M_AXIS_TVALID  out  1  scale valid.
- M_AXIS_TREADY  in  1  scale ready.
- err_tlast  out  1  one-cycle pulse on a TLAST / count mismatch.

## Operation
- FSM states: ACCUM, MEAN, CONV, SEND, WAIT_RSQ, OUT. Reset state is ACCUM. Only one vector is in flight at a time.
- ACCUM:
  - S_AXIS_TREADY = 1.
  - On each handshake: acc += x*x, where acc is unsigned, 32+LOG2_N bits, and x*x is a signed 16x16 product (max 2^30, never negative). cnt increments.
  - On the handshake with cnt == N-1, go to MEAN.
  - err_tlast pulses the cycle after any handshake where TLAST != (cnt == N-1).
  - The vector boundary is always taken from cnt; TLAST never ends or extends a vector.
- MEAN: register v = (acc >> LOG2_N) + EPS as 32-bit unsigned Q16.16. The sum cannot overflow for legal EPS < 2^31. Go to CONV.
- CONV: bf16 conversion of v, registered into M_AXIS_RSQ_TDATA. Go to SEND.
  - v == 0 gives 16'h0000.
  - Otherwise p = index of leading one (0..31).
  - exp = p + 111, sign = 0.
  - mant = the 7 bits below the leading one, zero-filled when p < 7.
  - Round to nearest even using the round bit and the sticky OR of the lower bits.
  - A rounding carry propagates into exp.
- SEND: M_AXIS_RSQ_TVALID = 1 with data held stable until M_AXIS_RSQ_TREADY. Then go to WAIT_RSQ.
- WAIT_RSQ: S_AXIS_RSQ_TREADY = 1. On handshake, capture S_AXIS_RSQ_TDATA into M_AXIS_TDATA and go to OUT.
- OUT: M_AXIS_TVALID = 1 with data held stable until M_AXIS_TREADY. Then clear acc and cnt and go to ACCUM.
- Every handshake is VALID & READY in the same cycle. Each READY is asserted only in its own state and does not depend on the matching VALID.

## Timing
- Reset values: S_AXIS_TREADY 0 during reset, 1 on the first cycle after. All other outputs 0: M_AXIS_RSQ_TVALID, S_AXIS_RSQ_TREADY, M_AXIS_TVALID, err_tlast, M_AXIS_RSQ_TDATA, M_AXIS_TDATA. Internal acc, cnt and state are cleared.
- Last-sample handshake in cycle t: MEAN in t+1, CONV in t+2, M_AXIS_RSQ_TVALID high from t+3.
- RSQ handshake in cycle u: S_AXIS_RSQ_TREADY high from u+1.
- Result handshake in cycle w: M_AXIS_TVALID high from w+1.
- Output handshake in cycle z: S_AXIS_TREADY high from z+1.
- Full throughput in ACCUM is one sample per cycle. Input bubbles (TVALID low) do not change acc or cnt.
- Reset asserted in any state takes effect at the next edge: the in-flight vector is discarded, all VALID/READY outputs drop, and no partial result is emitted.
- LOG2_N = 0: every sample is a complete vector.

## Test plan
- 64 samples of 16'h0100, EPS default, result returned as 16'h1234 -> M_AXIS_RSQ_TDATA = 16'h3F80; M_AXIS_TDATA = 16'h1234; err_tlast never pulses.
- 64 samples of 16'hFE00 (-2.0) -> 16'h4080. 64 zero samples -> 16'h3780.
- All-zero samples with EPS = 32'h0001_8180 -> 16'h3FC1 (round up). EPS = 32'h0001_8100 -> 16'h3FC0 (tie to even). EPS = 32'h0001_FF80 -> 16'h4000 (mantissa carry).
- Random TVALID gaps on the input plus M_AXIS_RSQ_TREADY and M_AXIS_TREADY held low for 5 cycles -> data stays stable while VALID is high; results match a reference model; exactly one output per vector; latencies exactly as in Timing.
- TLAST on sample 10, and none on sample 63 -> err_tlast pulses twice; the vector still closes after 64 samples with the correct value.
- areset pulsed during SEND, then a clean vector of 16'h0100 -> no stale output; the next output is 16'h3F80.
